// File: rtl/i2s_transmitter.sv
// Philips-format I2S serializer for the tone engine's stereo PCM output.
// A single-entry sample buffer absorbs the valid/ready handshake; empty frames go out as silence.
module i2s_transmitter #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_DIV     = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_l_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_r_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    i2s_bclk_out,
    output logic                    i2s_ws_out,
    output logic                    i2s_d_out,
    output logic                    underrun_out
);

    localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
    localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(FRAME_BITS - 2);

    // WS runs one slot ahead of the data so it leads each channel's MSB by one BCLK.
    function automatic logic ws_for_slot(input logic [CNT_W-1:0] slot);
        if ((slot >= WS_FIRST) && (slot <= WS_LAST)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    logic [DIV_W-1:0]        div_cnt_r;
    logic                    bclk_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [FRAME_BITS-1:0]   shift_r;
    logic [SAMPLE_WIDTH-1:0] buf_l_r;
    logic [SAMPLE_WIDTH-1:0] buf_r_r;
    logic                    buf_full_r;
    logic                    ws_r;
    logic                    sd_r;
    logic                    underrun_r;

    logic                    wrap_s;
    logic                    fall_s;
    logic                    load_s;
    logic                    accept_s;
    logic [DIV_W-1:0]        div_next_s;
    logic [CNT_W-1:0]        k_s;
    logic [FRAME_BITS-1:0]   shift_next_s;

    // Divider wrap, falling-event and frame-load decode, plus next shift-register contents.
    always_comb begin
        wrap_s   = (div_cnt_r == DIV_LAST);
        fall_s   = wrap_s && bclk_r;
        accept_s = sample_valid_in && !buf_full_r;

        if (wrap_s) begin
            div_next_s = '0;
        end else begin
            div_next_s = div_cnt_r + DIV_W'(1);
        end

        if (bit_cnt_r == CNT_LAST) begin
            k_s = '0;
        end else begin
            k_s = bit_cnt_r + CNT_W'(1);
        end

        load_s = fall_s && (k_s == '0);

        // A load with an empty buffer sends silence; a pair accepted this cycle waits a frame.
        if (load_s) begin
            if (buf_full_r) begin
                shift_next_s = {buf_l_r, buf_r_r};
            end else begin
                shift_next_s = '0;
            end
        end else if (fall_s) begin
            shift_next_s = {shift_r[FRAME_BITS-2:0], 1'b0};
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Bit-clock divider and frame slot counter.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            div_cnt_r <= '0;
            bclk_r    <= 1'b0;
            bit_cnt_r <= CNT_LAST;
        end else begin
            div_cnt_r <= div_next_s;
            if (wrap_s) begin
                bclk_r <= !bclk_r;
            end else begin
                bclk_r <= bclk_r;
            end
            if (fall_s) begin
                bit_cnt_r <= k_s;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Serial data path: shift register, registered SD/WS and the underrun pulse.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shift_r    <= '0;
            sd_r       <= 1'b0;
            ws_r       <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            shift_r    <= shift_next_s;
            sd_r       <= shift_next_s[FRAME_BITS-1];
            underrun_r <= load_s && !buf_full_r;
            if (fall_s) begin
                ws_r <= ws_for_slot(k_s);
            end else begin
                ws_r <= ws_r;
            end
        end
    end

    // Single-entry sample buffer; accept and drain can never coincide since accept needs it empty.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            buf_l_r    <= '0;
            buf_r_r    <= '0;
            buf_full_r <= 1'b0;
        end else begin
            if (accept_s) begin
                buf_l_r    <= sample_l_in;
                buf_r_r    <= sample_r_in;
                buf_full_r <= 1'b1;
            end else if (load_s) begin
                buf_l_r    <= buf_l_r;
                buf_r_r    <= buf_r_r;
                buf_full_r <= 1'b0;
            end else begin
                buf_l_r    <= buf_l_r;
                buf_r_r    <= buf_r_r;
                buf_full_r <= buf_full_r;
            end
        end
    end

    assign sample_ready_out = !buf_full_r;
    assign i2s_bclk_out     = bclk_r;
    assign i2s_ws_out       = ws_r;
    assign i2s_d_out        = sd_r;
    assign underrun_out     = underrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a frame-schedule model predicts each frame's
// contents; monitors reassemble frames from SD at rising BCLK and compare.
module tb_i2s_transmitter;

    localparam int W         = 16;
    localparam int DIV       = 4;
    localparam int FB        = 2 * W;
    localparam int FRAME_CLK = FB * 2 * DIV;
    localparam int LIMIT     = 3 * FRAME_CLK;

    typedef struct packed {
        logic [31:0] data;
        logic        under;
    } frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] l_a = 16'h0;
    logic [15:0] r_a = 16'h0;
    logic        v_a = 1'b0;
    logic        ready_a, bclk_a, ws_a, d_a, und_a;

    logic [15:0] l_b = 16'hA5F0;
    logic [15:0] r_b = 16'h0F5A;
    logic        v_b = 1'b1;
    logic        ready_b, bclk_b, ws_b, d_b, und_b;

    i2s_transmitter #(.SAMPLE_WIDTH(W), .BCLK_DIV(DIV)) dut_a (
        .clk_in(clk), .reset_n_in(rst_n),
        .sample_l_in(l_a), .sample_r_in(r_a), .sample_valid_in(v_a),
        .sample_ready_out(ready_a), .i2s_bclk_out(bclk_a), .i2s_ws_out(ws_a),
        .i2s_d_out(d_a), .underrun_out(und_a)
    );

    i2s_transmitter #(.SAMPLE_WIDTH(W), .BCLK_DIV(1)) dut_b (
        .clk_in(clk), .reset_n_in(rst_n),
        .sample_l_in(l_b), .sample_r_in(r_b), .sample_valid_in(v_b),
        .sample_ready_out(ready_b), .i2s_bclk_out(bclk_b), .i2s_ws_out(ws_b),
        .i2s_d_out(d_b), .underrun_out(und_b)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame loads happen at clock 2*DIV after reset release, then every FRAME_CLK clocks.
    function automatic bit is_load(input int n);
        return (n >= 2 * DIV) && (((n - 2 * DIV) % FRAME_CLK) == 0);
    endfunction

    function automatic logic ws_expect(input int j);
        return (j >= W - 1) && (j <= FB - 2);
    endfunction

    // Reference model: clock count since release, buffer occupancy, expected frame queue.
    int          mcyc;
    logic        mfull;
    logic [31:0] mbuf;
    logic        macc;
    frame_t      mfr;
    frame_t      exp_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mcyc  = 0;
            mfull = 1'b0;
            exp_q.delete();
        end else begin
            mcyc++;
            macc = v_a && !mfull;
            if (is_load(mcyc)) begin
                if (mfull) begin
                    mfr.data  = mbuf;
                    mfr.under = 1'b0;
                    mfull     = 1'b0;
                end else begin
                    mfr.data  = 32'h0;
                    mfr.under = 1'b1;
                end
                exp_q.push_back(mfr);
            end
            if (macc) begin
                mbuf  = {l_a, r_a};
                mfull = 1'b1;
            end
        end
    end

    // Ready must track the model's buffer occupancy every cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) chk("ready", {63'h0, ready_a}, {63'h0, !mfull});
    end

    // Monitor A: rebuild frames from SD at rising BCLK; the first rise precedes any frame.
    int          ra, ja, frames_a;
    logic        pb_a, uf_a;
    logic [31:0] fa;
    frame_t      got_a;

    initial begin
        frames_a = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ra = 0; pb_a = 1'b0; uf_a = 1'b0; fa = 32'h0;
            end else begin
                if (und_a) uf_a = 1'b1;
                if (bclk_a && !pb_a) begin
                    if (ra > 0) begin
                        ja = (ra - 1) % FB;
                        fa[31-ja] = d_a;
                        chk("a_ws", {63'h0, ws_a}, {63'h0, ws_expect(ja)});
                        if (ja == FB - 1) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                $display("FAIL a_frame: got %08h with no expected frame queued", fa);
                            end else begin
                                got_a = exp_q.pop_front();
                                chk("a_data", {32'h0, fa}, {32'h0, got_a.data});
                                chk("a_underrun", {63'h0, uf_a}, {63'h0, got_a.under});
                                frames_a++;
                            end
                            uf_a = 1'b0;
                        end
                    end
                    ra++;
                end
                pb_a = bclk_a;
            end
        end
    end

    // Monitor B (BCLK_DIV=1): fed the same pair continuously, so every frame is that pair.
    int          rb, jb, frames_b;
    logic        pb_b, uf_b;
    logic [31:0] fb_w;

    initial begin
        frames_b = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rb = 0; pb_b = 1'b0; uf_b = 1'b0; fb_w = 32'h0;
            end else begin
                if (und_b) uf_b = 1'b1;
                if (bclk_b && !pb_b) begin
                    if (rb > 0) begin
                        jb = (rb - 1) % FB;
                        fb_w[31-jb] = d_b;
                        chk("b_ws", {63'h0, ws_b}, {63'h0, ws_expect(jb)});
                        if (jb == FB - 1) begin
                            chk("b_data", {32'h0, fb_w}, 64'hA5F00F5A);
                            chk("b_underrun", {63'h0, uf_b}, 64'h0);
                            uf_b = 1'b0;
                            frames_b++;
                        end
                    end
                    rb++;
                end
                pb_b = bclk_b;
            end
        end
    end

    // Present a pair and hold it until the buffer takes it.
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        l_a = l; r_a = r; v_a = 1'b1;
        @(negedge clk);
        while (!ready_a && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (!ready_a) begin
            checks++;
            $display("FAIL send_timeout: ready still %0b after %0d cycles", ready_a, t);
        end
        @(posedge clk);
        #1;
        v_a = 1'b0;
        l_a = 16'($urandom); r_a = 16'($urandom);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Let a frame get going, then reset in the middle of it.
        send(16'h1234, 16'h5678);
        repeat (300) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bclk", {63'h0, bclk_a}, 64'h0);
        chk("rst_ws", {63'h0, ws_a}, 64'h0);
        chk("rst_sd", {63'h0, d_a}, 64'h0);
        chk("rst_underrun", {63'h0, und_a}, 64'h0);
        chk("rst_ready", {63'h0, ready_a}, 64'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1 chk("bclk_edge3", {63'h0, bclk_a}, 64'h0);
        @(posedge clk);
        #1 chk("bclk_edge4", {63'h0, bclk_a}, 64'h1);
        repeat (3) @(posedge clk);
        #1 chk("underrun_edge7", {63'h0, und_a}, 64'h0);
        @(posedge clk);
        #1 chk("underrun_edge8", {63'h0, und_a}, 64'h1);

        // Known pattern, then back-to-back random pairs.
        send(16'hA5F0, 16'h0F5A);
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));

        // Supply gap, then resume.
        repeat (3 * FRAME_CLK) @(posedge clk);
        send(16'($urandom), 16'($urandom));
        send(16'($urandom), 16'($urandom));

        // Accept on the exact cycle of a load with an empty buffer.
        t = 0;
        @(negedge clk);
        while (!(is_load(mcyc + 1) && !mfull) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            checks++;
            $display("FAIL load_accept_wait: no empty load cycle within %0d cycles", t);
        end
        l_a = 16'hC3E1; r_a = 16'h7E81; v_a = 1'b1;
        @(posedge clk);
        #1 v_a = 1'b0;

        // Randomly spaced supply.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            send(16'($urandom), 16'($urandom));
        end
        repeat (3 * FRAME_CLK) @(posedge clk);

        chk("a_frames_seen", {63'h0, (frames_a >= 12)}, 64'h1);
        chk("b_frames_seen", {63'h0, (frames_b >= 40)}, 64'h1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
